// File: rtl/rr_grant_encoder8.sv
// rr_grant_encoder8: round-robin 8-way arbiter driving a decoder's select/enable
// with bounded hold and a two-cycle break-before-make gap between grants.
module rr_grant_encoder8 #(
    parameter int HOLD_MAX = 4,
    parameter int CW       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       rel,
    output logic [2:0] w,
    output logic       en
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    state_t          state_q, state_d;
    logic [2:0]      ptr_q, ptr_d, w_q, w_d, pick;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            en_q, en_d, drop;
    // Scan from the far end so the set bit closest to ptr wins.
    always_comb begin
        pick = ptr_q;
        for (int i = 7; i >= 0; i--)
            if (req[ptr_q + 3'(i)]) pick = ptr_q + 3'(i);
    end
    assign drop = !req[w_q] || rel || (cnt_q == CW'(HOLD_MAX));
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        en_d    = en_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d = GRANT;
                w_d     = pick;
                en_d    = 1'b1;
                cnt_d   = CW'(1);
            end
            GRANT: if (drop) begin
                state_d = GAP;
                en_d    = 1'b0;
                ptr_d   = w_q + 3'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            w_q     <= '0;
            cnt_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
        end
    end
    assign w  = w_q;
    assign en = en_q;
endmodule
